// File: rtl/dmem_responder.sv
// dmem_responder
//   Target side of the core's memory-stage load/store interface. A word-organised
//   RAM (2^AW x 32) sits behind a one-entry store buffer: a store is captured at
//   the clock edge and committed to the array at the next edge. Loads are fully
//   combinational and forward bytes from the buffer when it holds the same word.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous active-low reset
//   addr       in   byte address; word index addr[AW+1:2], upper bits alias
//   wdata      in   store data, right-justified
//   we         in   store request
//   re         in   load request
//   size       in   [1:0] 00 byte / 01 half / 10 word / 11 illegal, [2] unsigned load
//   rdata      out  load result (combinational), 0 when idle or illegal
//   err        out  sticky misaligned / illegal-access flag
//   sb_pending out  store buffer holds an uncommitted store
//   load_cnt   out  accepted loads since reset (wraps)
//   store_cnt  out  accepted stores since reset (wraps)
module dmem_responder #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  size,
  output logic [31:0] rdata,
  output logic        err,
  output logic        sb_pending,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** AW;

  // ---------------------------------------------------------------------------
  // Helper functions: legality, store lane formation, byte merge, load extract
  // ---------------------------------------------------------------------------
  function automatic logic access_legal(input logic [1:0] sz, input logic [1:0] off);
    logic ok;
    case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] sz,
                                                     input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] raw,
                                                    input logic [DATA_W-1:0] fwd,
                                                    input logic [3:0]        be);
    logic [DATA_W-1:0] m;
    m = raw;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) m[8*b +: 8] = fwd[8*b +: 8];
    end
    return m;
  endfunction

  // Lane select followed by sign or zero extension; sz[2] selects unsigned.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        off,
                                                      input logic [2:0]        sz);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [DATA_W-1:0]  r;
    b_s = word[8*off +: 8];
    h_s = off[1] ? word[31:16] : word[15:0];
    case (sz[1:0])
      2'b00:   r = sz[2] ? {24'd0, b_s} : DATA_W'(b_s);
      2'b01:   r = sz[2] ? {16'd0, h_s} : DATA_W'(h_s);
      default: r = word;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              sb_valid_q, sb_valid_d;
  logic [AW-1:0]     sb_idx_q,   sb_idx_d;
  logic [DATA_W-1:0] sb_data_q,  sb_data_d;
  logic [3:0]        sb_be_q,    sb_be_d;
  logic              err_q,      err_d;
  logic [31:0]       load_cnt_q, load_cnt_d;
  logic [31:0]       store_cnt_q, store_cnt_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          legal;
  logic          ld_ok;
  logic          st_ok;
  logic          bad_access;
  logic          unused_addr_hi;

  assign idx            = addr[AW+1:2];
  assign off            = addr[1:0];
  assign unused_addr_hi = ^addr[31:AW+2];
  assign legal          = access_legal(size[1:0], off);
  assign ld_ok          = re & legal;
  assign st_ok          = we & legal;
  assign bad_access     = (re | we) & ~legal;

  // ---------------------------------------------------------------------------
  // Combinational load path: array read, buffer forwarding, lane extraction
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] raw_word;
  logic [DATA_W-1:0] fwd_word;

  assign raw_word = mem_q[idx];
  // Forward only while the buffer still holds an uncommitted store to this word.
  assign fwd_word = (sb_valid_q && (sb_idx_q == idx))
                    ? byte_merge(raw_word, sb_data_q, sb_be_q) : raw_word;

  always_comb begin
    rdata = '0;
    if (ld_ok) rdata = load_extract(fwd_word, off, size);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Without a new accepted store the buffer drains and goes empty; an
    // illegal store leaves the payload registers as they are.
    sb_valid_d  = st_ok;
    sb_idx_d    = sb_idx_q;
    sb_data_d   = sb_data_q;
    sb_be_d     = sb_be_q;
    err_d       = err_q | bad_access;
    load_cnt_d  = load_cnt_q  + {31'd0, ld_ok};
    store_cnt_d = store_cnt_q + {31'd0, st_ok};
    if (st_ok) begin
      sb_idx_d  = idx;
      sb_data_d = store_lanes(size[1:0], wdata);
      sb_be_d   = store_be(size[1:0], off);
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers (reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      sb_valid_q  <= sb_valid_d;
      err_q       <= err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer payload registers (no reset; qualified by sb_valid_q)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    sb_idx_q  <= sb_idx_d;
    sb_data_q <= sb_data_d;
    sb_be_q   <= sb_be_d;
  end

  // ---------------------------------------------------------------------------
  // Array commit: the buffered store lands at the next edge regardless of
  // whether a new store is arriving. Reset clears sb_valid_q asynchronously,
  // so a store buffered when reset asserts is never written.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sb_valid_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_be_q[b]) mem_q[sb_idx_q][8*b +: 8] <= sb_data_q[8*b +: 8];
      end
    end
  end

  assign err        = err_q;
  assign sb_pending = sb_valid_q;
  assign load_cnt   = load_cnt_q;
  assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [2:0]  size;
  logic [31:0] rdata;
  logic        err;
  logic        sb_pending;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  int n_tests;
  int n_fail;

  dmem_responder #(.AW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .re         (re),
    .size       (size),
    .rdata      (rdata),
    .err        (err),
    .sb_pending (sb_pending),
    .load_cnt   (load_cnt),
    .store_cnt  (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_pend;
    logic [31:0] exp_lcnt;
    logic [31:0] exp_scnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] s);
    we = w; re = r; addr = a; wdata = d; size = s;
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    dut.mem_q[10'h010] = 32'h8899AABB;
    dut.mem_q[10'h020] = 32'h01020304;
    dut.mem_q[10'h030] = 32'h00000000;
    dut.mem_q[10'h040] = 32'hCAFEF00D;

    //            we re addr          wdata         size    rdata         err pend lcnt  scnt
    vecs[0]  = '{1'b0,1'b0,32'h00000041,32'h0,        3'b000,32'h00000000,1'b0,1'b0,32'd0,32'd0};
    vecs[1]  = '{1'b0,1'b1,32'h00000041,32'h0,        3'b000,32'hFFFFFFAA,1'b0,1'b0,32'd0,32'd0};
    vecs[2]  = '{1'b0,1'b1,32'h00000042,32'h0,        3'b101,32'h00008899,1'b0,1'b0,32'd1,32'd0};
    vecs[3]  = '{1'b0,1'b1,32'h00000040,32'h0,        3'b010,32'h8899AABB,1'b0,1'b0,32'd2,32'd0};
    vecs[4]  = '{1'b0,1'b1,32'h00000040,32'h0,        3'b100,32'h000000BB,1'b0,1'b0,32'd3,32'd0};
    vecs[5]  = '{1'b0,1'b1,32'h00000040,32'h0,        3'b001,32'hFFFFAABB,1'b0,1'b0,32'd4,32'd0};
    vecs[6]  = '{1'b1,1'b0,32'h00000043,32'h0000005A, 3'b000,32'h00000000,1'b0,1'b0,32'd5,32'd0};
    vecs[7]  = '{1'b0,1'b1,32'h00000040,32'h0,        3'b010,32'h5A99AABB,1'b0,1'b1,32'd5,32'd1};
    vecs[8]  = '{1'b0,1'b0,32'h00000040,32'h0,        3'b010,32'h00000000,1'b0,1'b0,32'd6,32'd1};
    vecs[9]  = '{1'b0,1'b1,32'h00000040,32'h0,        3'b010,32'h5A99AABB,1'b0,1'b0,32'd6,32'd1};
    vecs[10] = '{1'b1,1'b0,32'h00000081,32'h0000FFFF, 3'b001,32'h00000000,1'b0,1'b0,32'd7,32'd1};
    vecs[11] = '{1'b0,1'b1,32'h00000082,32'h0,        3'b010,32'h00000000,1'b1,1'b0,32'd7,32'd1};
    vecs[12] = '{1'b0,1'b1,32'h00000080,32'h0,        3'b010,32'h01020304,1'b1,1'b0,32'd7,32'd1};
    vecs[13] = '{1'b0,1'b1,32'h00000040,32'h0,        3'b011,32'h00000000,1'b1,1'b0,32'd8,32'd1};
    vecs[14] = '{1'b0,1'b1,32'h00000042,32'h0,        3'b000,32'hFFFFFF99,1'b1,1'b0,32'd8,32'd1};
    vecs[15] = '{1'b0,1'b1,32'h00001040,32'h0,        3'b010,32'h5A99AABB,1'b1,1'b0,32'd9,32'd1};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].size);
      #4;
      chk($sformatf("v%0d rdata", i),     rdata,             vecs[i].exp_rdata);
      chk($sformatf("v%0d err", i),       {31'd0, err},        {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d sb_pending", i), {31'd0, sb_pending}, {31'd0, vecs[i].exp_pend});
      chk($sformatf("v%0d load_cnt", i),  load_cnt,          vecs[i].exp_lcnt);
      chk($sformatf("v%0d store_cnt", i), store_cnt,         vecs[i].exp_scnt);
      next_cycle();
    end

    // Asynchronous reset mid-cycle clears sticky err and counters.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    reset = 1'b0;
    #4;
    chk("rst err",       {31'd0, err},        32'd0);
    chk("rst pending",   {31'd0, sb_pending}, 32'd0);
    chk("rst load_cnt",  load_cnt,            32'd0);
    chk("rst store_cnt", store_cnt,           32'd0);
    chk("rst rdata",     rdata,               32'd0);
    next_cycle();
    reset = 1'b1;

    // Back-to-back stores to one word, then read back through the buffer.
    drive(1'b1, 1'b0, 32'h80, 32'h11111111, 3'b010);
    next_cycle();
    drive(1'b1, 1'b0, 32'h82, 32'h00002222, 3'b001);
    next_cycle();
    drive(1'b1, 1'b0, 32'h80, 32'h00000033, 3'b000);
    next_cycle();
    drive(1'b0, 1'b1, 32'h80, 32'h0, 3'b010);
    #4;
    chk("b2b rdata",     rdata,               32'h22221133);
    chk("b2b store_cnt", store_cnt,           32'd3);
    chk("b2b pending",   {31'd0, sb_pending}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    next_cycle();
    drive(1'b0, 1'b1, 32'h80, 32'h0, 3'b010);
    #4;
    chk("b2b array rdata", rdata, 32'h22221133);
    next_cycle();

    // A store still in the buffer when reset asserts must be discarded.
    drive(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'b010);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    reset = 1'b0;
    #4;
    chk("discard pending",   {31'd0, sb_pending}, 32'd0);
    chk("discard store_cnt", store_cnt,           32'd0);
    chk("discard load_cnt",  load_cnt,            32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h100, 32'h0, 3'b010);
    #4;
    chk("discard rdata", rdata, 32'hCAFEF00D);
    next_cycle();

    // Load and store to the same word in one cycle.
    drive(1'b1, 1'b1, 32'hC0, 32'h12345678, 3'b010);
    #4;
    chk("rw rdata",    rdata,    32'h00000000);
    chk("rw load_cnt", load_cnt, 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 32'hC0, 32'h0, 3'b010);
    #4;
    chk("rw next rdata",     rdata,               32'h12345678);
    chk("rw next load_cnt",  load_cnt,            32'd2);
    chk("rw next store_cnt", store_cnt,           32'd1);
    chk("rw next pending",   {31'd0, sb_pending}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
